gpu_scanout: RTL

Display scanout stage downstream of the GPU frame-buffer memory controller. Generates horizontal and vertical video timing, reads the frame buffer that is not currently being drawn from the read port of the dual-port frame SRAM, and emits an aligned RGB pixel stream with sync and data-enable. The displayed buffer is taken from the memory controller's `buffer_select` at frame boundaries only, so a buffer swap never tears mid-frame.

---
 rtl/gpu_scanout.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/gpu_scanout.sv
// Display scanout: video timing generator, frame-buffer read addressing and
// a fixed 3-cycle pipeline that aligns colour with sync/DE/frame_start.
module gpu_scanout #(
  parameter int unsigned CHANNEL_BITS = 8,
  parameter int unsigned WIDTH_BITS   = 9,
  parameter int unsigned HEIGHT_BITS  = 9,
  parameter int unsigned H_ACTIVE     = 320,
  parameter int unsigned H_FP         = 8,
  parameter int unsigned H_SYNC       = 32,
  parameter int unsigned H_BP         = 40,
  parameter int unsigned V_ACTIVE     = 240,
  parameter int unsigned V_FP         = 3,
  parameter int unsigned V_SYNC       = 4,
  parameter int unsigned V_BP         = 6
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic                                buffer_select_i,
  input  logic [3*CHANNEL_BITS-1:0]           rd_data_i,
  output logic [WIDTH_BITS+HEIGHT_BITS:0]     rd_addr_o,
  output logic                                rd_oe_o,
  output logic                                rd_ce_o,
  output logic [3*CHANNEL_BITS-1:0]           rgb_o,
  output logic                                de_o,
  output logic                                hsync_o,
  output logic                                vsync_o,
  output logic                                frame_start_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Counters must hold every boundary value and also supply the address slice.
  localparam int unsigned HC_MIN  = $clog2(H_TOTAL + 1);
  localparam int unsigned VC_MIN  = $clog2(V_TOTAL + 1);
  localparam int unsigned HCW     = (HC_MIN > WIDTH_BITS)  ? HC_MIN : WIDTH_BITS;
  localparam int unsigned VCW     = (VC_MIN > HEIGHT_BITS) ? VC_MIN : HEIGHT_BITS;
  localparam int unsigned AW      = WIDTH_BITS + HEIGHT_BITS + 1;
  localparam int unsigned PW      = 3 * CHANNEL_BITS;

  localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_ACT    = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] HS_START = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] HS_END   = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_ACT    = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] VS_START = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VS_END   = VCW'(V_ACTIVE + V_FP + V_SYNC);

  // Stage 0: counters and displayed-buffer latch
  logic [HCW-1:0] hc_q, hc_d;
  logic [VCW-1:0] vc_q, vc_d;
  logic           disp_buf_q, disp_buf_d;
  logic           act0, hs0_n, vs0_n, fs0, buf0;

  // Stage 1: SRAM address/enables plus delayed flags
  logic [AW-1:0]  addr_q, addr_d;
  logic           en_n_q;
  logic           act1_q, hs1_q, vs1_q, fs1_q;

  // Stage 2: flags waiting for SRAM data
  logic           act2_q, hs2_q, vs2_q, fs2_q;

  // Stage 3: output registers
  logic [PW-1:0]  rgb_q;
  logic           de_q, hsync_q, vsync_q, fs3_q;

  // Stage-0 decode: counter advance, region flags, buffer selection, address
  always_comb begin
    hc_d = hc_q + 1'b1;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
    end
    act0  = (hc_q < H_ACT) && (vc_q < V_ACT);
    hs0_n = !((hc_q >= HS_START) && (hc_q < HS_END));
    vs0_n = !((vc_q >= VS_START) && (vc_q < VS_END));
    fs0   = (hc_q == '0) && (vc_q == '0);
    // The frame-start cycle itself already addresses the newly latched buffer,
    // so the select input is used directly there instead of the register.
    buf0       = fs0 ? ~buffer_select_i : disp_buf_q;
    disp_buf_d = buf0;
    addr_d     = addr_q;
    if (act0) begin
      addr_d = {buf0, vc_q[HEIGHT_BITS-1:0], hc_q[WIDTH_BITS-1:0]};
    end
  end

  // Stage-0 state registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hc_q       <= '0;
      vc_q       <= '0;
      disp_buf_q <= 1'b0;
    end else begin
      hc_q       <= hc_d;
      vc_q       <= vc_d;
      disp_buf_q <= disp_buf_d;
    end
  end

  // Stages 1 and 2: registered SRAM request and flag delay line
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr_q <= '0;
      en_n_q <= 1'b1;
      act1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      fs1_q  <= 1'b0;
      act2_q <= 1'b0;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
      fs2_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      en_n_q <= ~act0;
      act1_q <= act0;
      hs1_q  <= hs0_n;
      vs1_q  <= vs0_n;
      fs1_q  <= fs0;
      act2_q <= act1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      fs2_q  <= fs1_q;
    end
  end

  // Stage 3: capture pixel data (blanked outside active) with aligned sync/DE
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rgb_q   <= '0;
      de_q    <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      fs3_q   <= 1'b0;
    end else begin
      rgb_q   <= act2_q ? rd_data_i : '0;
      de_q    <= act2_q;
      hsync_q <= hs2_q;
      vsync_q <= vs2_q;
      fs3_q   <= fs2_q & act2_q;
    end
  end

  assign rd_addr_o     = addr_q;
  assign rd_ce_o       = en_n_q;
  assign rd_oe_o       = en_n_q;
  assign rgb_o         = rgb_q;
  assign de_o          = de_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign frame_start_o = fs3_q;

endmodule
